// File: rtl/datapath_pkg.sv
// Shared integer-datapath definitions: widths and ALU opcodes.
package datapath_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // ALU opcodes, shared with the ALU itself.
    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] AND = 3'd2;
    localparam logic [2:0] OR  = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] SLT = 3'd5;

endpackage

// File: rtl/regfile_2r1w.sv
// 32 x 32 register file: two combinational read ports, one clocked write port.
// x0 is hard-wired to zero; a same-cycle write to a read index is bypassed.
module regfile_2r1w
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [1 << REG_AW];

    // Clocked write; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << REG_AW); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Read port 1 with x0 forcing and write-through bypass.
    always_comb begin
        rd1 = mem[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    // Read port 2 with x0 forcing and write-through bypass.
    always_comb begin
        rd2 = mem[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: register file, EX/WB forwarding,
// immediate select and a valid/ready output register feeding the ALU.
//
// Handshake: a transfer in happens when InValid && InReady && !Flush.
// InReady = !OutValid || OutReady (Flush does not affect it). A transfer out
// happens when OutValid && OutReady. While OutValid && !OutReady every output
// holds. Flush drops both the held and the incoming instruction.
module alu_operand_stage
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [REG_AW-1:0] Rs1,
    input  logic [REG_AW-1:0] Rs2,
    input  logic [REG_AW-1:0] Rd,
    input  logic [DATA_W-1:0] Imm,
    input  logic              ALUSrc,
    input  logic [2:0]        ALUControlIn,
    input  logic              RegWriteIn,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] SrcA,
    output logic [DATA_W-1:0] SrcB,
    output logic [2:0]        ALUControl,
    output logic [REG_AW-1:0] RdOut,
    output logic              RegWriteOut,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              WbEn,
    input  logic [REG_AW-1:0] WbAddr,
    input  logic [DATA_W-1:0] WbData
);

    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] src_b_next;
    logic              accept;

    regfile_2r1w u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (Rs1),
        .rd1   (rf_rd1),
        .ra2   (Rs2),
        .rd2   (rf_rd2),
        .we    (WbEn),
        .wa    (WbAddr),
        .wd    (WbData)
    );

    // Operand priority: x0, then the instruction in the ALU, then writeback,
    // then the register file. ALUResult only reaches flop D inputs here.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [REG_AW-1:0] rs,
        input logic [DATA_W-1:0] rf_val
    );
        if (rs == '0) begin
            return '0;
        end else if (OutValid && RegWriteOut && (RdOut == rs)) begin
            return ALUResult;
        end else if (WbEn && (WbAddr == rs)) begin
            return WbData;
        end
        return rf_val;
    endfunction

    // Resolve both operands and apply the immediate select.
    always_comb begin
        op_a       = resolve(Rs1, rf_rd1);
        op_b       = resolve(Rs2, rf_rd2);
        src_b_next = ALUSrc ? Imm : op_b;
    end

    assign InReady = !OutValid || OutReady;
    assign accept  = InValid && InReady && !Flush;

    // Output pipeline register: load on accept, drain on OutReady, kill on Flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OutValid    <= 1'b0;
            SrcA        <= '0;
            SrcB        <= '0;
            ALUControl  <= ADD;
            RdOut       <= '0;
            RegWriteOut <= 1'b0;
        end else if (Flush) begin
            OutValid <= 1'b0;
        end else if (accept) begin
            OutValid    <= 1'b1;
            SrcA        <= op_a;
            SrcB        <= src_b_next;
            ALUControl  <= ALUControlIn;
            RdOut       <= Rd;
            RegWriteOut <= RegWriteIn;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;
    import datapath_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        InValid;
    logic        InReady;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rd;
    logic [31:0] Imm;
    logic        ALUSrc;
    logic [2:0]  ALUControlIn;
    logic        RegWriteIn;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic [4:0]  RdOut;
    logic        RegWriteOut;
    logic [31:0] ALUResult;
    logic        WbEn;
    logic [4:0]  WbAddr;
    logic [31:0] WbData;

    int total = 0;
    int bad   = 0;

    alu_operand_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .InValid      (InValid),
        .InReady      (InReady),
        .Rs1          (Rs1),
        .Rs2          (Rs2),
        .Rd           (Rd),
        .Imm          (Imm),
        .ALUSrc       (ALUSrc),
        .ALUControlIn (ALUControlIn),
        .RegWriteIn   (RegWriteIn),
        .Flush        (Flush),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .ALUControl   (ALUControl),
        .RdOut        (RdOut),
        .RegWriteOut  (RegWriteOut),
        .ALUResult    (ALUResult),
        .WbEn         (WbEn),
        .WbAddr       (WbAddr),
        .WbData       (WbData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic src, input logic [31:0] imm,
                            input logic [2:0] ctl, input logic rw);
        InValid      = v;
        Rs1          = r1;
        Rs2          = r2;
        Rd           = rd;
        ALUSrc       = src;
        Imm          = imm;
        ALUControlIn = ctl;
        RegWriteIn   = rw;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        WbEn   = en;
        WbAddr = a;
        WbData = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        Flush     = 1'b0;
        OutReady  = 1'b1;
        ALUResult = '0;
        drive_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 32'h5, OR, 1'b1);
        drive_wb(1'b0, 5'd0, 32'h0);
        step();
        chk("reset_inready", {31'd0, InReady}, 32'd1);
        chk("reset_outvalid", {31'd0, OutValid}, 32'd0);
        step();
        rst_n = 1'b1;

        // Load x5 and capture it, then reset mid-stream.
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ADD, 1'b0);
        drive_wb(1'b1, 5'd5, 32'h0000_00AB);
        step();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_in(1'b1, 5'd5, 5'd0, 5'd9, 1'b0, 32'h0, OR, 1'b1);
        step();
        chk("pre_reset_srca", SrcA, 32'h0000_00AB);
        chk("pre_reset_valid", {31'd0, OutValid}, 32'd1);
        #2 rst_n = 1'b0;
        ALUControlIn = XOR;
        #1;
        chk("mid_reset_valid", {31'd0, OutValid}, 32'd0);
        chk("mid_reset_srca", SrcA, 32'h0);
        chk("mid_reset_srcb", SrcB, 32'h0);
        chk("mid_reset_ctl", {29'd0, ALUControl}, 32'd0);
        chk("mid_reset_rd", {27'd0, RdOut}, 32'd0);
        chk("mid_reset_rw", {31'd0, RegWriteOut}, 32'd0);
        step();
        rst_n = 1'b1;
        drive_in(1'b1, 5'd5, 5'd0, 5'd1, 1'b0, 32'h0, ADD, 1'b0);
        step();
        chk("x5_after_reset", SrcA, 32'h0);

        // Plain register read.
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ADD, 1'b0);
        drive_wb(1'b1, 5'd3, 32'h0000_0010);
        step();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_in(1'b1, 5'd3, 5'd0, 5'd1, 1'b0, 32'h0, ADD, 1'b0);
        step();
        chk("rf_read_srca", SrcA, 32'h0000_0010);
        chk("rf_read_srcb", SrcB, 32'h0);
        chk("rf_read_ctl", {29'd0, ALUControl}, 32'd0);
        chk("rf_read_valid", {31'd0, OutValid}, 32'd1);

        // EX forward from the held instruction writing x4.
        drive_in(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 32'h0, SUB, 1'b1);
        step();
        chk("ex_held_rd", {27'd0, RdOut}, 32'd4);
        ALUResult = 32'hDEAD_BEEF;
        drive_in(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 32'h0, AND, 1'b1);
        step();
        chk("ex_fwd_srca", SrcA, 32'hDEAD_BEEF);
        chk("ex_fwd_ctl", {29'd0, ALUControl}, {29'd0, AND});
        // Held instruction targets x0: reading x0 must not pick up ALUResult.
        drive_in(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 32'h0, ADD, 1'b1);
        step();
        chk("ex_x0_srca", SrcA, 32'h0);

        // EX beats WB on the same index.
        ALUResult = 32'h0000_2222;
        drive_wb(1'b1, 5'd6, 32'h0000_1111);
        drive_in(1'b1, 5'd6, 5'd6, 5'd2, 1'b0, 32'h0, ADD, 1'b0);
        step();
        chk("ex_over_wb_srcb", SrcB, 32'h0000_2222);
        chk("ex_over_wb_srca", SrcA, 32'h0000_2222);
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_in(1'b1, 5'd6, 5'd6, 5'd2, 1'b1, 32'hFFFF_FFF0, ADD, 1'b0);
        step();
        chk("imm_srcb", SrcB, 32'hFFFF_FFF0);
        chk("x6_written_srca", SrcA, 32'h0000_1111);

        // WB forward alone (held instruction does not write).
        drive_wb(1'b1, 5'd8, 32'h0000_0088);
        drive_in(1'b1, 5'd8, 5'd0, 5'd2, 1'b1, 32'h0000_1234, SLT, 1'b0);
        step();
        chk("wb_fwd_srca", SrcA, 32'h0000_0088);
        chk("wb_fwd_srcb", SrcB, 32'h0000_1234);
        drive_wb(1'b0, 5'd0, 32'h0);

        // Backpressure: outputs hold for 3 cycles, a writeback to x8 does not leak in.
        OutReady = 1'b0;
        drive_in(1'b1, 5'd3, 5'd0, 5'd1, 1'b0, 32'h0, XOR, 1'b0);
        #1;
        chk("bp_inready_comb", {31'd0, InReady}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_wb(i == 0, 5'd8, 32'h0000_0999);
            step();
            chk("bp_inready", {31'd0, InReady}, 32'd0);
            chk("bp_valid", {31'd0, OutValid}, 32'd1);
            chk("bp_srca", SrcA, 32'h0000_0088);
            chk("bp_srcb", SrcB, 32'h0000_1234);
            chk("bp_ctl", {29'd0, ALUControl}, {29'd0, SLT});
        end
        drive_wb(1'b0, 5'd0, 32'h0);
        OutReady = 1'b1;
        #1;
        chk("bp_release_inready", {31'd0, InReady}, 32'd1);
        step();
        chk("bp_load_srca", SrcA, 32'h0000_0010);
        chk("bp_load_srcb", SrcB, 32'h0);
        chk("bp_load_ctl", {29'd0, ALUControl}, {29'd0, XOR});

        // Flush with a held instruction and a stalled downstream.
        OutReady = 1'b0;
        Flush    = 1'b1;
        drive_in(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 32'h0000_0999, SUB, 1'b1);
        drive_wb(1'b1, 5'd7, 32'h0000_0055);
        #1;
        chk("flush_inready", {31'd0, InReady}, 32'd0);
        step();
        chk("flush_valid", {31'd0, OutValid}, 32'd0);
        chk("flush_srca_hold", SrcA, 32'h0000_0010);
        chk("flush_srcb_hold", SrcB, 32'h0);
        chk("flush_rd_hold", {27'd0, RdOut}, 32'd1);
        Flush    = 1'b0;
        OutReady = 1'b1;
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_in(1'b1, 5'd7, 5'd8, 5'd3, 1'b0, 32'h0, ADD, 1'b0);
        step();
        chk("flush_x7_visible", SrcA, 32'h0000_0055);
        chk("x8_rewritten", SrcB, 32'h0000_0999);

        // Drain.
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ADD, 1'b0);
        step();
        chk("drain_valid", {31'd0, OutValid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand stage directly upstream of the ALU in the integer datapath. Holds the 32-entry register file, resolves operands with EX/WB forwarding and immediate selection, and presents SrcA, SrcB and ALUControl to the ALU from a valid/ready pipeline register. The ALU's combinational ALUResult feeds back into this stage as the EX forwarding source.

## Interface
- No parameters. Data width is fixed at 32 and register count at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  upstream presents an instruction.
- InReady  out  1  stage accepts this cycle.
- Rs1, Rs2  in  5  source register indices.
- Rd  in  5  destination index.
- Imm  in  32  sign-extended immediate.
- ALUSrc  in  1  1 selects Imm for SrcB.
- ALUControlIn  in  3  ALU opcode, passed through.
- RegWriteIn  in  1  instruction writes Rd.
- Flush  in  1  synchronous kill of the held and the incoming instruction.
- OutValid  out  1  output register holds an instruction.
- OutReady  in  1  downstream consumes this cycle.
- SrcA, SrcB  out  32  operands to the ALU.
- ALUControl  out  3  opcode to the ALU.
- RdOut  out  5  destination of the held instruction.
- RegWriteOut  out  1  write-enable of the held instruction.
- ALUResult  in  32  ALU output for the held instruction.
- WbEn  in  1  register-file write enable.
- WbAddr  in  5  write index.
- WbData  in  32  write data.

## Operation
**Register file**
- x0 reads 0; writes to x0 are ignored.
- Writes happen on the clk edge when WbEn=1.
- Reads are combinational. The RTL includes a write-through bypass: WbEn && WbAddr==Rs && Rs!=0 returns WbData.

**Operand resolution (per source Rs)**
- Priority 1: if Rs==0, the operand is 0.
- Priority 2 (EX forward): if OutValid && RegWriteOut && RdOut==Rs, the operand is ALUResult.
- Priority 3 (WB forward): if WbEn && WbAddr==Rs, the operand is WbData.
- Otherwise the operand is the register-file read.
- SrcA next value = resolved Rs1.
- SrcB next value = ALUSrc ? Imm : resolved Rs2.

**Handshake**
- InReady = !OutValid || OutReady, independent of Flush.
- Accept = InValid && InReady && !Flush.
- On accept, the output register loads SrcA, SrcB, ALUControlIn, Rd and RegWriteIn, and OutValid becomes 1.
- If no accept and OutReady=1, OutValid becomes 0; data fields hold.
- If OutValid && !OutReady, all outputs hold unchanged. Captured operands are not refreshed by later writebacks.
- Flush=1 clears OutValid next cycle and blocks accept. The register-file write in the same cycle still occurs.

**Writeback contract**
- Downstream must assert WbEn for an accepted RegWrite instruction no later than the cycle after OutValid && OutReady.
- This guarantees that a back-to-back dependent instruction sees the EX forward, and one arriving a cycle later sees the WB forward.

## Timing
- Latency: an input accepted at edge t appears on the outputs after edge t; ALUResult for it is valid in the same cycle.
- Throughput: one instruction per cycle when OutReady=1.
- Reset values: OutValid=0, SrcA=0, SrcB=0, ALUControl=0, RdOut=0, RegWriteOut=0, all registers 0. InReady reads 1 during reset.
- Reset asserted mid-operation drops the held instruction immediately. No partial state survives.
- Simultaneous EX and WB match on the same Rs: EX wins.
- Simultaneous writeback and read of the same index: the new data is used.
- The ALUResult-to-D path is combinational through the forward mux only. There is no combinational loop, because SrcA and SrcB come from flops.

## Structure
- Shared package `datapath_pkg` holds:
  - DATA_W=32, REG_AW=5;
  - ALU opcode constants ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, shared with the ALU.
- One sub-module: `regfile_2r1w`, with 2 combinational read ports, 1 synchronous write port, x0 forced to 0 and write-through bypass.
- Forwarding, the immediate mux and the pipeline register live in the top.

## Test plan
- Reset with rst_n=0 mid-stream, inputs toggling: all outputs 0, OutValid=0; after release, reading x5 returns 0.
- WbEn writes x3=0x0000_0010, then accept Rs1=3, Rs2=0, ALUSrc=0, ALUControlIn=0: SrcA=0x10, SrcB=0, ALUControl=0.
- EX forward: held instruction has Rd=4, RegWriteOut=1, ALUResult driven 0xDEAD_BEEF; next input Rs1=4 → SrcA=0xDEAD_BEEF. Repeat with Rd=0 → SrcA=0.
- EX over WB priority: WbEn with x6=0x1111 in the same cycle as an EX match on Rd=6 with ALUResult=0x2222; input Rs2=6 → SrcB=0x2222. With ALUSrc=1 and Imm=0xFFFF_FFF0 → SrcB=0xFFFF_FFF0.
- Backpressure: OutValid=1, OutReady=0 for 3 cycles with InValid=1: InReady=0 and SrcA/SrcB stable. OutReady=1 then loads the next instruction on the following edge.
- Flush: Flush=1 with InValid=1, OutValid=1: OutValid=0 next cycle, the input is not captured, and a concurrent WbEn write of x7=0x55 is still visible afterwards.
